// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state enum, the data width and a safe log2 helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    // Width needed to index n items, never less than 1.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_monitor_sync_fifo.sv
// Synchronous FIFO with a registered first-word-through head.
// Ports: clk_i/rst_i, push_i/push_data_i, pop_i, data_o (head), full_o, empty_o.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2_safe(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [AW:0]      w_wptr_n;
    logic [AW:0]      w_rptr_n;
    logic             w_bypass;

    assign w_full = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = pop_i & r_valid;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_do_push = push_i & (~w_full | w_do_pop);

    assign w_wptr_n = r_wptr + {{AW{1'b0}}, w_do_push};
    assign w_rptr_n = r_rptr + {{AW{1'b0}}, w_do_pop};

    // The next head is the entry being written this cycle.
    assign w_bypass = w_do_push &&
                      (r_wptr[AW-1:0] == w_rptr_n[AW-1:0]);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_valid <= (w_wptr_n != w_rptr_n);
            if (w_wptr_n != w_rptr_n) begin
                r_dout <= w_bypass ? push_data_i
                                   : r_mem[w_rptr_n[AW-1:0]];
            end
        end
    end

    assign data_o  = r_dout;
    assign full_o  = w_full;
    assign empty_o = ~r_valid;

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling FSM, receive FIFO.
// Ports: clk_i, rst_i, rx_i in; rx_data_o/rx_valid_o/rx_ready_i stream;
// frame_err_o, overflow_o status pulses; busy_o when not idle.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int DIV_W = clog2_safe(CLK_DIV);
    localparam int BIT_W = clog2_safe(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_rx_state_e       r_state;
    uart_rx_state_e       w_state_n;

    logic                 r_sync1;
    logic                 r_rx_s;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_push;
    logic                 r_ferr;
    logic                 r_ovf;

    logic                 w_tick;
    logic                 w_push_req;
    logic                 w_ferr_req;
    logic                 w_busy;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_drop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (!r_rx_s) w_state_n = START;
            end
            START: begin
                if (w_tick) w_state_n = r_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (w_tick && r_bit_cnt == BIT_LAST) w_state_n = STOP;
            end
            STOP: begin
                if (w_tick) w_state_n = r_rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (r_rx_s) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != IDLE);
        w_push_req = 1'b0;
        w_ferr_req = 1'b0;
        if (r_state == STOP && w_tick) begin
            w_push_req = r_rx_s;
            w_ferr_req = ~r_rx_s;
        end
    end

    // Entering START loads half a period so samples land mid-bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div <= '0;
        end else if (w_state_n != r_state) begin
            r_div <= (w_state_n == START) ? DIV_HALF : '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (r_state == START && w_state_n == DATA) begin
            r_bit_cnt <= '0;
        end else if (r_state == DATA && w_tick) begin
            r_shreg   <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
    end

    // A full FIFO drops the byte unless the consumer pops this cycle.
    assign w_drop = r_push & w_fifo_full & ~(rx_valid_o & rx_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_push <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_push <= w_push_req;
            r_ferr <= w_ferr_req;
            r_ovf  <= w_drop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_push),
        .push_data_i (r_shreg),
        .pop_i       (rx_ready_i),
        .data_o      (rx_data_o),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    assign rx_valid_o  = ~w_fifo_empty;
    assign frame_err_o = r_ferr;
    assign overflow_o  = r_ovf;
    assign busy_o      = w_busy;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- 8N1 UART receiver that decodes the SoC's uart_tx_o line.
- Instantiated in simulation benches, and usable as a synthesizable RX peripheral.
- Oversamples the serial line with a fixed clock divider, validates start and stop bits, and buffers received bytes in a small FIFO.
- Presents bytes on a valid/ready stream with framing-error and overflow status pulses.

Parameters:
- CLK_DIV, 16: clocks per bit period; must be even and >= 4.
- FIFO_DEPTH, 8: receive FIFO entries; must be a power of two and >= 2.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial line; idle high; asynchronous to clk_i.
- rx_data_o  output  8  byte at the FIFO head.
- rx_valid_o  output  1  FIFO non-empty.
- rx_ready_i  input  1  consumer accepts the head when rx_valid_o && rx_ready_i.
- frame_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
- overflow_o  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst_i is high, all state clears immediately.
  - Synchronizer flops reset to 1.
  - FSM resets to IDLE; bit counter and divider reset to 0.
  - FIFO is emptied.
  - Outputs: rx_data_o=0, rx_valid_o=0, frame_err_o=0, overflow_o=0, busy_o=0.
  - Reset mid-frame discards the partial byte. After release, the receiver waits for the next falling edge; no spurious byte or error is produced.
- Input sync: 2-flop synchronizer on rx_i; the synchronized value is rx_s. All FSM decisions use rx_s, adding 2 cycles of latency.
- Divider: counter div_q runs 0..CLK_DIV-1. A "tick" occurs when div_q reaches its terminal value. div_q reloads at each state entry.
- FSM states:
  - IDLE: on rx_s==0, go to START and load the divider for a half period (CLK_DIV/2).
  - START: at the tick, if rx_s==0, go to DATA with bit_cnt=0 and a full period. If rx_s==1, it is a false start: return to IDLE with no output.
  - DATA: at each tick, shift rx_s into shreg[7] (right shift, LSB first) and increment bit_cnt. After the 8th sample, go to STOP.
  - STOP: at the tick, if rx_s==1, request a push of shreg and go to IDLE. If rx_s==0, pulse frame_err_o, drop the byte, and go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This stops a held-low line from being re-read as start bits.
- Sampling: every bit is sampled at mid-bit. The start-bit sample falls CLK_DIV/2 cycles after the edge is seen on rx_s; each later sample falls CLK_DIV cycles after the previous one.
- Push timing: the push is registered into the FIFO on the cycle after the stop-bit tick. rx_valid_o rises on the next cycle (registered read, first-word-through head).
- FIFO:
  - Pop occurs when rx_valid_o && rx_ready_i.
  - Push when full: if a pop happens in the same cycle, the push is accepted. Otherwise the byte is dropped, overflow_o pulses, and FIFO contents are unchanged.
  - Simultaneous push and pop when non-empty leaves the count unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. rx_data_o must stay stable while rx_valid_o && !rx_ready_i.
- frame_err_o and overflow_o are registered, high for exactly one cycle, and never both high in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - the state enum uart_rx_state_e {IDLE, START, DATA, STOP, BREAK};
  - localparam DATA_BITS=8;
  - a function clog2-safe width helper.
- One sub-module, sync_fifo: parameterized width and depth, with push/pop, full/empty and registered head. The top level holds the synchronizer, divider and FSM.

Test Plan:
All scenarios use CLK_DIV=16 and FIFO_DEPTH=8.
1. Send 0xA5 as 8N1 at 16 clocks/bit with rx_ready_i=1 → exactly one rx_valid_o beat with rx_data_o=0xA5. No frame_err_o or overflow_o.
2. Drive rx_i low for 4 cycles, then high → busy_o pulses, then the FSM returns to IDLE. No byte, no error.
3. Send 0x3C with the stop bit held low for 40 cycles → frame_err_o pulses once and no byte is queued. A following valid 0x5A is received correctly.
4. Hold rx_ready_i=0 and send 9 bytes 0x01..0x09 → overflow_o pulses once, on the 9th byte. Raising ready then drains 0x01..0x08 in order, and rx_valid_o then drops.
5. Fill the FIFO to 8 entries, then set rx_ready_i=1 so a pop coincides with the 9th push → no overflow. Drain order is 0x02..0x09.
6. Assert rst_i at bit 4 of 0xFF, release, then send 0x81 → only 0x81 is received. All outputs are 0 during reset.
